// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline widths, opcodes and IF/ID register type
package mips_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - ROM, decode-control and IF/ID signals of the fetch stage
interface fetch_stage_if;
    import mips_pkg::*;

    logic [PC_W-1:0]    rom_addr_o;
    logic [INSTR_W-1:0] rom_q_i;
    logic               stall_i;
    logic               redirect_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic               if_valid_o;
    logic [INSTR_W-1:0] if_instr_o;
    logic [PC_W-1:0]    if_pc_o;
    logic [PC_W-1:0]    if_pc_plus1_o;

    modport master (
        output rom_addr_o,
        input  rom_q_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        output if_valid_o,
        output if_instr_o,
        output if_pc_o,
        output if_pc_plus1_o
    );

    modport slave (
        input  rom_addr_o,
        output rom_q_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        input  if_valid_o,
        input  if_instr_o,
        input  if_pc_o,
        input  if_pc_plus1_o
    );

endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, 1-cycle synchronous ROM addressing, IF/ID register
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            f_vld_q, f_vld_d;
    ifid_t           ifid_q, ifid_d;

    // The ROM latches pc_d on the same edge pc_q takes it, so rom_q_i always matches pc_q.
    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (rst) begin
            pc_d = RESET_PC;
        end else if (bus.redirect_i) begin
            pc_d = bus.redirect_pc_i;
        end else if (!f_vld_q || bus.stall_i) begin
            pc_d = pc_q;
        end
    end

    assign f_vld_d = !rst;

    always_comb begin
        ifid_d = ifid_q;
        if (rst) begin
            ifid_d = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else if (bus.redirect_i) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (!bus.stall_i) begin
            ifid_d.valid = f_vld_q;
            ifid_d.instr = f_vld_q ? bus.rom_q_i : NOP_INSTR;
            ifid_d.pc    = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        f_vld_q <= f_vld_d;
        ifid_q  <= ifid_d;
    end

    assign bus.rom_addr_o    = pc_d;
    assign bus.if_valid_o    = ifid_q.valid;
    assign bus.if_instr_o    = ifid_q.instr;
    assign bus.if_pc_o       = ifid_q.pc;
    assign bus.if_pc_plus1_o = ifid_q.pc + PC_W'(1);

endmodule
